// File: rtl/cs_pkg.sv
// Shared definitions for the compressed-sensing encoder/decoder pair: the
// FSM state type, the measurement-matrix LFSR and sign hash, and the
// compression-ratio to measurement-count table.
package cs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEED,
    ST_PROJECT,
    ST_EMIT,
    ST_DONE
  } state_t;

  localparam logic [31:0] LFSR_DEFAULT = 32'hDEADBEEF;

  // One advance of the matrix LFSR (taps 31, 21, 1, 0).
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Matrix sign for row m: only m mod 32 matters, since both bit indices
  // are taken mod 32. 1 means +y[m], 0 means -y[m].
  function automatic logic sign_bit(input logic [31:0] lfsr, input logic [4:0] m_lo);
    logic [4:0] a;
    logic [4:0] b;
    a = m_lo * 5'd7;
    b = m_lo * 5'd13 + 5'd3;
    return lfsr[a] ^ lfsr[b];
  endfunction

  // Measurements per frame, floor(n / cr); unsupported ratios behave as 4.
  function automatic logic [9:0] num_meas(input logic [3:0] cr, input int unsigned n);
    case (cr)
      4'd2:    return 10'(n / 2);
      4'd3:    return 10'(n / 3);
      4'd4:    return 10'(n / 4);
      4'd5:    return 10'(n / 5);
      4'd6:    return 10'(n / 6);
      4'd7:    return 10'(n / 7);
      4'd8:    return 10'(n / 8);
      4'd9:    return 10'(n / 9);
      4'd10:   return 10'(n / 10);
      default: return 10'(n / 4);
    endcase
  endfunction

endpackage

// File: rtl/cs_decoder_if.sv
// Streaming bus carrying {Q, I} sample pairs with valid/ready/last handshake.
interface cs_decoder_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [2*DATA_WIDTH-1:0] tdata;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cs_meas_buffer.sv
// Single-port synchronous RAM holding one frame of measurements.
// Read data appears one cycle after the address is presented.
module cs_meas_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write on enable, registered read every cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cs_decoder.sv
// Compressed-sensing back-projection decoder. Buffers one frame of M complex
// measurements, regenerates the encoder's +/-1 matrix from the shared seed
// and streams N samples x[n] = sum_m Phi[m,n] * y[m], shifted and saturated.
module cs_decoder
  import cs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned OUTPUT_SIZE  = 1024,
  parameter int unsigned MAX_COMPRESS = 10,
  parameter int unsigned LFSR_WIDTH   = 32,
  parameter int unsigned ACC_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cs_decoder_if.slave           s_axis,
  cs_decoder_if.master          m_axis,
  input  logic [3:0]            cfg_compress_ratio,
  input  logic [LFSR_WIDTH-1:0] cfg_lfsr_seed,
  input  logic [3:0]            cfg_out_shift,
  input  logic                  cfg_enable,
  output logic                  busy,
  output logic                  err_len,
  output logic [9:0]            m_len
);

  localparam int unsigned DEPTH = OUTPUT_SIZE / 2;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned NW    = $clog2(OUTPUT_SIZE);
  localparam int unsigned W2    = 2 * DATA_WIDTH;
  localparam logic [NW-1:0] N_LAST = NW'(OUTPUT_SIZE - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  state_t r_state;
  state_t w_state_nxt;

  logic [LFSR_WIDTH-1:0]       r_seed;
  logic [3:0]                  r_shift;
  logic [9:0]                  r_m_tgt;
  logic [9:0]                  r_load_cnt;
  logic [9:0]                  r_m_len;
  logic                        r_err_len;
  logic [LFSR_WIDTH-1:0]       r_lfsr;
  logic [NW-1:0]               r_n;
  logic [9:0]                  r_rd_cnt;
  logic                        r_rd_vld;
  logic                        r_rd_sign;
  logic signed [ACC_WIDTH-1:0] r_acc_i;
  logic signed [ACC_WIDTH-1:0] r_acc_q;
  logic [W2-1:0]               r_out_data;
  logic                        r_out_valid;
  logic                        r_out_last;

  logic                        w_start;
  logic                        w_cr_ok;
  logic                        w_beat_acc;
  logic [9:0]                  w_load_cnt_inc;
  logic                        w_load_end;
  logic                        w_rd_issue;
  logic                        w_proj_end;
  logic                        w_xfer;
  logic [AW-1:0]               w_buf_addr;
  logic [W2-1:0]               w_rdata;
  logic signed [ACC_WIDTH-1:0] w_y_i;
  logic signed [ACC_WIDTH-1:0] w_y_q;

  // Arithmetic shift followed by clamp to the signed DATA_WIDTH range.
  function automatic logic [DATA_WIDTH-1:0] sat_shift(input logic signed [ACC_WIDTH-1:0] a,
                                                       input logic [3:0] sh);
    logic signed [ACC_WIDTH-1:0] s;
    s = a >>> sh;
    if (s > SAT_MAX) begin
      s = SAT_MAX;
    end else if (s < SAT_MIN) begin
      s = SAT_MIN;
    end
    return s[DATA_WIDTH-1:0];
  endfunction

  assign w_start        = cfg_enable && s_axis.tvalid;
  assign w_cr_ok        = (cfg_compress_ratio >= 4'd2) &&
                          (32'(cfg_compress_ratio) <= 32'(MAX_COMPRESS));
  assign w_beat_acc     = (r_state == ST_LOAD) && s_axis.tvalid;
  assign w_load_cnt_inc = r_load_cnt + 10'd1;
  assign w_load_end     = w_beat_acc && (s_axis.tlast || (w_load_cnt_inc == r_m_tgt));
  assign w_rd_issue     = (r_state == ST_PROJECT) && (r_rd_cnt < r_m_len);
  assign w_proj_end     = (r_state == ST_PROJECT) && (r_rd_cnt == r_m_len + 10'd1);
  assign w_xfer         = (r_state == ST_EMIT) && r_out_valid && m_axis.tready;
  assign w_buf_addr     = (r_state == ST_LOAD) ? r_load_cnt[AW-1:0] : r_rd_cnt[AW-1:0];

  assign w_y_i = {{(ACC_WIDTH-DATA_WIDTH){w_rdata[DATA_WIDTH-1]}}, w_rdata[DATA_WIDTH-1:0]};
  assign w_y_q = {{(ACC_WIDTH-DATA_WIDTH){w_rdata[W2-1]}}, w_rdata[W2-1:DATA_WIDTH]};

  cs_meas_buffer #(
    .WIDTH (W2),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_beat_acc),
    .i_addr  (w_buf_addr),
    .i_wdata (s_axis.tdata),
    .o_rdata (w_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_state_nxt = ST_LOAD;
      ST_LOAD:    if (w_load_end) w_state_nxt = ST_SEED;
      ST_SEED:    w_state_nxt = ST_PROJECT;
      ST_PROJECT: if (w_proj_end) w_state_nxt = ST_EMIT;
      ST_EMIT:    if (w_xfer) w_state_nxt = (r_n == N_LAST) ? ST_DONE : ST_PROJECT;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Config latch, frame load, read/accumulate pipeline and output register.
  // Read issue at cycle k, data valid at k+1, accumulated at the k+1 edge;
  // the final sum is therefore stable when r_rd_cnt reaches m_len+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seed      <= '0;
      r_shift     <= '0;
      r_m_tgt     <= '0;
      r_load_cnt  <= '0;
      r_m_len     <= '0;
      r_err_len   <= 1'b0;
      r_lfsr      <= LFSR_DEFAULT;
      r_n         <= '0;
      r_rd_cnt    <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_sign   <= 1'b0;
      r_acc_i     <= '0;
      r_acc_q     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_err_len <= 1'b0;
      r_rd_vld  <= w_rd_issue;
      r_rd_sign <= sign_bit(r_lfsr, r_rd_cnt[4:0]);
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_seed     <= cfg_lfsr_seed;
            r_shift    <= cfg_out_shift;
            r_m_tgt    <= w_cr_ok ? num_meas(cfg_compress_ratio, OUTPUT_SIZE)
                                  : num_meas(4'd4, OUTPUT_SIZE);
            r_load_cnt <= '0;
            r_m_len    <= '0;
          end
        end
        ST_LOAD: begin
          if (w_beat_acc) begin
            r_load_cnt <= w_load_cnt_inc;
            r_m_len    <= w_load_cnt_inc;
            if (s_axis.tlast != (w_load_cnt_inc == r_m_tgt)) begin
              r_err_len <= 1'b1;
            end
          end
        end
        ST_SEED: begin
          r_lfsr   <= r_seed;
          r_n      <= '0;
          r_rd_cnt <= '0;
          r_acc_i  <= '0;
          r_acc_q  <= '0;
        end
        ST_PROJECT: begin
          r_rd_cnt <= r_rd_cnt + 10'd1;
          if (r_rd_vld) begin
            r_acc_i <= r_rd_sign ? (r_acc_i + w_y_i) : (r_acc_i - w_y_i);
            r_acc_q <= r_rd_sign ? (r_acc_q + w_y_q) : (r_acc_q - w_y_q);
          end
          if (w_proj_end) begin
            r_out_data  <= {sat_shift(r_acc_q, r_shift), sat_shift(r_acc_i, r_shift)};
            r_out_valid <= 1'b1;
            r_out_last  <= (r_n == N_LAST);
          end
        end
        ST_EMIT: begin
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_lfsr      <= lfsr_step(r_lfsr);
            r_n         <= r_n + 1'b1;
            r_rd_cnt    <= '0;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axis.tready = (r_state == ST_LOAD);
  assign m_axis.tdata  = r_out_data;
  assign m_axis.tvalid = r_out_valid;
  assign m_axis.tlast  = r_out_last;
  assign busy          = (r_state != ST_IDLE);
  assign err_len       = r_err_len;
  assign m_len         = r_m_len;

endmodule

// File: tb/tb_cs_decoder.sv
// Scoreboard bench for cs_decoder. Runs the decoder with a reduced frame of
// 64 output samples so that every scenario (including CR=2) stays short; the
// golden Phi^T y model is evaluated in the bench and queued per frame.
module tb_cs_decoder;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cs_decoder_if #(.DATA_WIDTH(DW)) s_axis ();
  cs_decoder_if #(.DATA_WIDTH(DW)) m_axis ();

  logic [3:0]  cfg_compress_ratio;
  logic [31:0] cfg_lfsr_seed;
  logic [3:0]  cfg_out_shift;
  logic        cfg_enable;
  logic        busy;
  logic        err_len;
  logic [9:0]  m_len;

  cs_decoder #(
    .DATA_WIDTH   (DW),
    .OUTPUT_SIZE  (N),
    .MAX_COMPRESS (10),
    .LFSR_WIDTH   (32),
    .ACC_WIDTH    (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis             (s_axis),
    .m_axis             (m_axis),
    .cfg_compress_ratio (cfg_compress_ratio),
    .cfg_lfsr_seed      (cfg_lfsr_seed),
    .cfg_out_shift      (cfg_out_shift),
    .cfg_enable         (cfg_enable),
    .busy               (busy),
    .err_len            (err_len),
    .m_len              (m_len)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic signed [15:0] y_i [N/2];
  logic signed [15:0] y_q [N/2];
  logic [32:0]        sb_q [$];

  int rx_cnt  = 0;
  int err_cnt = 0;
  bit rdy_random = 1'b0;

  function automatic logic [31:0] model_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic logic [15:0] model_sat(input longint v, input int sh);
    longint s;
    s = v >>> sh;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  // Golden adjoint: one queue entry {tlast, Q, I} per output sample.
  task automatic push_expected(input logic [31:0] seed, input int mlen, input int sh);
    logic [31:0] l;
    longint si, sq;
    int a, b;
    l = seed;
    for (int n = 0; n < int'(N); n++) begin
      si = 0;
      sq = 0;
      for (int m = 0; m < mlen; m++) begin
        a = (7 * m) % 32;
        b = (13 * m + 3) % 32;
        if (l[a] ^ l[b]) begin
          si += longint'(y_i[m]);
          sq += longint'(y_q[m]);
        end else begin
          si -= longint'(y_i[m]);
          sq -= longint'(y_q[m]);
        end
      end
      sb_q.push_back({(n == int'(N) - 1), model_sat(sq, sh), model_sat(si, sh)});
      l = model_step(l);
    end
  endtask

  // Output monitor: scoreboard pop on transfer, hold check during stalls.
  initial begin
    logic        prev_stall;
    logic [32:0] prev_beat;
    logic [32:0] e;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("ready_valid_exclusive", 64'(s_axis.tready & m_axis.tvalid), 64'd0);
        if (err_len) err_cnt++;
        if (prev_stall) begin
          chk("stall_tvalid_held", 64'(m_axis.tvalid), 64'd1);
          chk("stall_beat_held", 64'({m_axis.tlast, m_axis.tdata}), 64'(prev_beat));
        end
        if (m_axis.tvalid && m_axis.tready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", 64'(sb_q.size() > 0), 64'd1);
          end else begin
            e = sb_q.pop_front();
            chk("out_data", 64'(m_axis.tdata), 64'(e[31:0]));
            chk("out_last", 64'(m_axis.tlast), 64'(e[32]));
          end
          rx_cnt++;
        end
        prev_stall = m_axis.tvalid && !m_axis.tready;
        prev_beat  = {m_axis.tlast, m_axis.tdata};
      end
    end
  end

  // Downstream ready: always high, or a coin flip every cycle.
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis.tready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check_reset_values(input string ctx);
    chk({ctx, "_s_tready"}, 64'(s_axis.tready), 64'd0);
    chk({ctx, "_m_tvalid"}, 64'(m_axis.tvalid), 64'd0);
    chk({ctx, "_m_tlast"},  64'(m_axis.tlast),  64'd0);
    chk({ctx, "_m_tdata"},  64'(m_axis.tdata),  64'd0);
    chk({ctx, "_busy"},     64'(busy),          64'd0);
    chk({ctx, "_err_len"},  64'(err_len),       64'd0);
    chk({ctx, "_m_len"},    64'(m_len),         64'd0);
  endtask

  // Queue the expected frame and feed nbeats measurements; config is
  // scrambled afterwards since it must only be sampled at frame start.
  task automatic load_frame(input logic [3:0] cr, input logic [31:0] seed, input logic [3:0] sh,
                            input int nbeats, input int last_at, input int mlen);
    bit acc;
    int guard;
    push_expected(seed, mlen, int'(sh));
    cfg_compress_ratio = cr;
    cfg_lfsr_seed      = seed;
    cfg_out_shift      = sh;
    cfg_enable         = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = {y_q[b], y_i[b]};
      s_axis.tlast  = (b == last_at);
      guard = 0;
      do begin
        @(negedge clk);
        acc = s_axis.tready;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 100);
      if (!acc) chk("beat_accepted", 64'(acc), 64'd1);
    end
    s_axis.tvalid      = 1'b0;
    s_axis.tlast       = 1'b0;
    cfg_enable         = 1'b0;
    cfg_compress_ratio = 4'd3;
    cfg_lfsr_seed      = $urandom;
    cfg_out_shift      = 4'd7;
  endtask

  task automatic run_frame(input logic [3:0] cr, input logic [31:0] seed, input logic [3:0] sh,
                           input int nbeats, input int last_at, input int mlen, input int exp_err);
    int e0, r0, cyc, limit;
    e0 = err_cnt;
    r0 = rx_cnt;
    load_frame(cr, seed, sh, nbeats, last_at, mlen);
    limit = int'(N) * (mlen + 4) * 6 + 200;
    cyc = 0;
    while ((rx_cnt - r0) < int'(N) && cyc < limit) begin
      @(posedge clk);
      cyc++;
    end
    cyc = 0;
    while (busy && cyc < 20) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("rx_count", 64'(rx_cnt - r0), 64'(N));
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    chk("err_len_pulses", 64'(err_cnt - e0), 64'(exp_err));
    chk("m_len", 64'(m_len), 64'(mlen));
    chk("busy_after_frame", 64'(busy), 64'd0);
  endtask

  task automatic fill_random(input int cnt, input int sparse);
    for (int m = 0; m < int'(N / 2); m++) begin
      if (m < cnt && (sparse == 0 || $urandom_range(0, 3) == 0)) begin
        y_i[m] = 16'($signed($urandom_range(0, 8000)) - 4000);
        y_q[m] = 16'($signed($urandom_range(0, 8000)) - 4000);
      end else begin
        y_i[m] = '0;
        y_q[m] = '0;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int r0, cyc;
    s_axis.tvalid      = 1'b0;
    s_axis.tlast       = 1'b0;
    s_axis.tdata       = '0;
    cfg_compress_ratio = 4'd4;
    cfg_lfsr_seed      = '0;
    cfg_out_shift      = '0;
    cfg_enable         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Impulse: only y[0] non-zero, output sign follows lfsr_n[0]^lfsr_n[3].
    fill_random(0, 0);
    y_i[0] = 16'sd1000;
    y_q[0] = -16'sd1000;
    run_frame(4'd8, 32'h0000_0001, 4'd0, 8, 7, 8, 0);

    // Sparse random measurements, CR=4.
    fill_random(16, 1);
    run_frame(4'd4, 32'hACE1_ACE1, 4'd0, 16, 15, 16, 0);

    // Same frame under random backpressure.
    rdy_random = 1'b1;
    run_frame(4'd4, 32'hACE1_ACE1, 4'd0, 16, 15, 16, 0);
    rdy_random = 1'b0;

    // Saturation at CR=2, then a shift large enough to avoid clamping.
    for (int m = 0; m < int'(N / 2); m++) begin
      y_i[m] = 16'sd32767;
      y_q[m] = -16'sd32768;
    end
    run_frame(4'd2, 32'h1234_5678, 4'd0, 32, 31, 32, 0);
    run_frame(4'd2, 32'h0000_0000, 4'd9, 32, 31, 32, 0);

    // Short frame: tlast on beat 10 of 16.
    fill_random(16, 0);
    run_frame(4'd4, 32'h0BAD_F00D, 4'd0, 10, 9, 10, 1);

    // Full-length frame (CR=5) without tlast.
    fill_random(12, 0);
    run_frame(4'd5, 32'hCAFE_0001, 4'd2, 12, -1, 12, 1);

    // Unsupported ratios decode as CR=4.
    fill_random(16, 0);
    run_frame(4'd0, 32'h5555_AAAA, 4'd1, 16, 15, 16, 0);
    run_frame(4'd13, 32'h0F0F_0F0F, 4'd0, 16, 15, 16, 0);

    // Reset while projecting sample 37, then a clean frame.
    fill_random(16, 0);
    r0 = rx_cnt;
    load_frame(4'd4, 32'h7777_1111, 4'd0, 16, 15, 16);
    cyc = 0;
    while ((rx_cnt - r0) < 37 && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    chk("pre_reset_transfers", 64'(rx_cnt - r0), 64'd37);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("midframe_reset");
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = rx_cnt;
    repeat (60) @(posedge clk);
    #1;
    chk("no_output_after_reset", 64'(rx_cnt - r0), 64'd0);
    chk("idle_after_reset", 64'(busy), 64'd0);
    fill_random(21, 0);
    run_frame(4'd3, 32'hDEAD_BEEF, 4'd0, 21, 20, 21, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cs_decoder.md
# cs_decoder

Compressed-sensing back-projection decoder: the receive-side counterpart of the CS encoder. It buffers one frame of M compressed complex measurements and regenerates the encoder's LFSR Bernoulli ±1 matrix Φ from the same seed. It then streams N reconstructed samples x̂[n] = Σ_m Φ[m,n]·y[m] (adjoint estimate), scaled and saturated. It sits after the compressed link, ahead of the sparse-recovery/detection stage.

## Interface
- DATA_WIDTH, 16, I/Q component width
- OUTPUT_SIZE, 1024, N reconstructed samples per frame
- MAX_COMPRESS, 10, maximum compression ratio
- LFSR_WIDTH, 32, matrix LFSR width
- ACC_WIDTH, 32, signed accumulator width (worst case 512·2^15 = 2^24 fits)
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  2*DATA_WIDTH  measurement {Q, I}, signed
- s_axis_tvalid / s_axis_tlast  in  1  input handshake / last measurement
- s_axis_tready  out  1  high only in ST_LOAD
- m_axis_tdata  out  2*DATA_WIDTH  reconstructed {Q, I}
- m_axis_tvalid / m_axis_tlast  out  1  output valid / sample N-1
- m_axis_tready  in  1  downstream ready
- cfg_compress_ratio  in  4  2–10; other values mean 4
- cfg_lfsr_seed  in  LFSR_WIDTH  must equal encoder seed
- cfg_out_shift  in  4  arithmetic right shift applied before saturation
- cfg_enable  in  1  frame start permitted
- busy  out  1  state != ST_IDLE
- err_len  out  1  one-cycle pulse on frame-length mismatch
- m_len  out  10  measurements captured in current frame

## Operation
- M = floor(1024/CR): CR 2..10 -> 512, 341, 256, 204, 170, 146, 128, 113, 102.
- Config latched on the IDLE->LOAD transition. It is ignored mid-frame.
- LFSR next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}. Seed is loaded as-is; a zero seed is legal and gives all-minus signs, matching the encoder.
- lfsr_n is the LFSR state after n advances from the seed.
- Sign for (m, n): s = lfsr_n[(7m)%32] ^ lfsr_n[(13m+3)%32]. s=1 adds y[m]; s=0 subtracts y[m]. I and Q use the same sign.
- States:
  - ST_IDLE: go to ST_LOAD when cfg_enable && s_axis_tvalid.
  - ST_LOAD: each accepted beat writes buffer[load_cnt]. The state exits on an accepted beat with tlast, or on beat M.
  - If tlast arrives before beat M, or beat M arrives without tlast: pulse err_len. m_len is the count actually accepted.
  - Any beats beyond M are left stalled and belong to the next frame.
  - ST_SEED: lfsr <= latched seed; n <= 0.
  - ST_PROJECT: issue reads m = 0..m_len-1, one per cycle, then drain the read/accumulate pipeline. Go to ST_EMIT.
  - ST_EMIT: hold output until m_axis_tready. On the transfer, advance LFSR, clear acc, and n++. Go to ST_PROJECT, or to ST_DONE after n = N-1.
  - ST_DONE: one cycle, then go to ST_IDLE.
- Output: out = sat_DATA_WIDTH(acc >>> cfg_out_shift), clamped to [-32768, 32767] per component.
- m_axis_tlast is asserted with n = N-1.

## Timing
- Buffer read latency is 1 cycle; the accumulate register adds 1 cycle.
- m_axis_tvalid rises m_len+2 cycles after entering ST_PROJECT for each n.
- Frame time ≈ M + 2 + N·(M+3) cycles with tready held high.
- m_axis_tdata and tlast are held stable while tvalid && !tready. tvalid never drops without a transfer.
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, err_len=0, m_len=0, state=ST_IDLE, lfsr=32'hDEADBEEF.
- Reset asserted mid-frame takes effect on the next clock. The partial frame is discarded and no further outputs are produced.
- s_axis_tready and m_axis_tvalid are never high in the same cycle.

## Structure
- Package cs_pkg holds:
  - state_t enum
  - lfsr_step() function
  - sign_bit(lfsr, m) hash function
  - num_meas(cr) table function
  - LFSR default constant 32'hDEADBEEF
- The encoder migrates to cs_pkg so the matrix definition exists once.
- Sub-module cs_meas_buffer: single-port synchronous RAM, N/2 × 2·DATA_WIDTH (512×32), 1-cycle read latency.

## Test plan
- Impulse: CR=8, seed 0x00000001, y[0]=(I=1000, Q=-1000), y[1..127]=0, shift 0 -> 1024 outputs with I=±1000 and Q=∓1000. Sign = lfsr_n[0]^lfsr_n[3]. tlast only on sample 1023.
- Round trip: random sparse 1024-sample spectrum -> encoder (CR=4, seed 0xACE1ACE1) -> cs_decoder, checked bit-exact against the Φᵀy golden model. err_len stays 0.
- Saturation: CR=2, all y=(32767, -32768), shift 0 -> every output within [-32768, 32767] and clamped where |sum| exceeds range. With shift 9 -> no clamping.
- Short frame: CR=4 with tlast on beat 100 -> err_len pulses once, m_len=100, 1024 outputs using only y[0..99].
- Backpressure: m_axis_tready random 50% -> tdata/tlast stable during stalls, exactly 1024 transfers, same data as the ready=1 run.
- Reset mid-ST_PROJECT at n=37 -> next cycle all outputs at reset values. A following full frame decodes correctly.
